// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole owner of the 8x8 register file write port.
// Arbitrates ALU and load write-back requests (valid/ready), commits the
// winner through one registered stage and tracks a per-register busy
// scoreboard for issue-stage hazard stalls.
// Optional build macro: REGWB_R0_ZERO_EN (r0 hardwired to zero).
module regfile_wb_arbiter #(
    parameter int unsigned MAX_CONSEC = 3,
    parameter int unsigned NREG       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [2:0]      alu_reg,
    input  logic [7:0]      alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [2:0]      mem_reg,
    input  logic [7:0]      mem_data,
    output logic            mem_ready,
    input  logic            issue_valid,
    input  logic [2:0]      issue_reg,
    output logic            RegWrite,
    output logic [2:0]      WriteReg,
    output logic [7:0]      WriteData,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    localparam int unsigned RegW    = 3;
    localparam int unsigned DataW   = 8;
    localparam int unsigned StreakW = 4;

    logic               aluGrant;
    logic               memGrant;
    logic [StreakW-1:0] streak;
    logic [StreakW-1:0] streakNext;
    logic [RegW-1:0]    selReg;
    logic [DataW-1:0]   selData;
    logic               commitEn;
    logic               issueSet;
    logic               writeBusy;
    logic               errSet;
    logic [NREG-1:0]    busyNext;

    // Grant selection: MEM preferred, ALU forced once MEM has won MAX_CONSEC times in a row
    always_comb begin
        aluGrant = 1'b0;
        memGrant = 1'b0;
        if (mem_valid && !(alu_valid && (streak == StreakW'(MAX_CONSEC)))) begin
            memGrant = 1'b1;
        end else if (alu_valid) begin
            aluGrant = 1'b1;
        end
    end

    assign alu_ready = aluGrant;
    assign mem_ready = memGrant;

    // Streak of MEM wins that kept a waiting ALU out; saturates at MAX_CONSEC
    always_comb begin
        streakNext = streak;
        if (aluGrant) begin
            streakNext = '0;
        end else if (memGrant && alu_valid && (streak < StreakW'(MAX_CONSEC))) begin
            streakNext = streak + StreakW'(1);
        end
    end

    // Winner payload and whether it actually reaches the register file
    always_comb begin
        selReg   = memGrant ? mem_reg  : alu_reg;
        selData  = memGrant ? mem_data : alu_data;
`ifdef REGWB_R0_ZERO_EN
        commitEn = (aluGrant || memGrant) && (selReg != RegW'(0));
        issueSet = issue_valid && (issue_reg != RegW'(0));
`else
        commitEn = aluGrant || memGrant;
        issueSet = issue_valid;
`endif
    end

    // Busy bit of the register currently being committed
    always_comb begin
        writeBusy = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (WriteReg == RegW'(i)) begin
                writeBusy = busy[i];
            end
        end
`ifdef REGWB_R0_ZERO_EN
        errSet = RegWrite && !writeBusy && (WriteReg != RegW'(0));
`else
        errSet = RegWrite && !writeBusy;
`endif
    end

    // Scoreboard update: commit clears first, issue sets after so a new writer wins
    always_comb begin
        busyNext = busy;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (RegWrite && (WriteReg == RegW'(i))) begin
                busyNext[i] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < NREG; i++) begin
            if (issueSet && (issue_reg == RegW'(i))) begin
                busyNext[i] = 1'b1;
            end
        end
    end

    // Commit stage, scoreboard, streak and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            busy      <= '0;
            wb_err    <= 1'b0;
            streak    <= '0;
        end else begin
            RegWrite <= commitEn;
            if (commitEn) begin
                WriteReg  <= selReg;
                WriteData <= selData;
            end
            busy   <= busyNext;
            streak <= streakNext;
            if (errSet) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter with a commit scoreboard queue.
module tb_regfile_wb_arbiter;

`ifdef REGWB_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    localparam logic [7:0] BusyR0 = R0Z ? 8'h10 : 8'h11;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid, mem_valid, issue_valid;
    logic [2:0] alu_reg, mem_reg, issue_reg;
    logic [7:0] alu_data, mem_data;
    logic       alu_ready, mem_ready;
    logic       RegWrite;
    logic [2:0] WriteReg;
    logic [7:0] WriteData;
    logic [7:0] busy;
    logic       wb_err;

    regfile_wb_arbiter #(.MAX_CONSEC(3), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [2:0] ar;
        logic [7:0] ad;
        logic       mv;
        logic [2:0] mr;
        logic [7:0] md;
        logic       iv;
        logic [2:0] ir;
        logic       expA;
        logic       expM;
        logic [7:0] expBusy;
        logic       expErr;
    } vec_t;

    typedef struct {
        logic [2:0] r;
        logic [7:0] d;
    } commit_t;

    vec_t    vecs[$];
    commit_t sb[$];
    int      checks = 0;
    int      errors = 0;
    logic [2:0] lastReg = 3'd0;
    logic [7:0] lastData = 8'd0;

    function automatic vec_t mk(logic av, logic [2:0] ar, logic [7:0] ad,
                                logic mv, logic [2:0] mr, logic [7:0] md,
                                logic iv, logic [2:0] ir,
                                logic ea, logic em, logic [7:0] eb, logic ee);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv; v.mr = mr; v.md = md;
        v.iv = iv; v.ir = ir;
        v.expA = ea; v.expM = em; v.expBusy = eb; v.expErr = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idleInputs();
        alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 8'd0;
        mem_valid = 1'b0; mem_reg = 3'd0; mem_data = 8'd0;
        issue_valid = 1'b0; issue_reg = 3'd0;
    endtask

    // Compare the commit stage against the scoreboard head (or an idle hold)
    task automatic checkCommit(input int idx);
        commit_t c;
        if (sb.size() > 0) begin
            c = sb.pop_front();
            chk($sformatf("v%0d RegWrite", idx), 32'(RegWrite), 32'd1);
            chk($sformatf("v%0d WriteReg", idx), 32'(WriteReg), 32'(c.r));
            chk($sformatf("v%0d WriteData", idx), 32'(WriteData), 32'(c.d));
            lastReg = c.r;
            lastData = c.d;
        end else begin
            chk($sformatf("v%0d RegWrite idle", idx), 32'(RegWrite), 32'd0);
            chk($sformatf("v%0d WriteReg hold", idx), 32'(WriteReg), 32'(lastReg));
            chk($sformatf("v%0d WriteData hold", idx), 32'(WriteData), 32'(lastData));
        end
    endtask

    initial begin
        // issue/commit r3 through the ALU
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd3, 0,0, 8'h08,0));
        vecs.push_back(mk(1,3'd3,8'h5A, 0,3'd0,8'h00, 0,3'd0, 1,0, 8'h08,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,0, 8'h00,0));
        // both valid: MEM first, then ALU
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd1, 0,0, 8'h02,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd2, 0,0, 8'h06,0));
        vecs.push_back(mk(1,3'd1,8'h11, 1,3'd2,8'h22, 0,3'd0, 0,1, 8'h06,0));
        vecs.push_back(mk(1,3'd1,8'h11, 0,3'd0,8'h00, 0,3'd0, 1,0, 8'h02,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,0, 8'h00,0));
        // starvation guard: grant order M,M,M,A,M,M
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd7, 0,0, 8'h80,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd5, 0,0, 8'hA0,0));
        vecs.push_back(mk(1,3'd7,8'h77, 1,3'd5,8'h30, 1,3'd5, 0,1, 8'hA0,0));
        vecs.push_back(mk(1,3'd7,8'h77, 1,3'd5,8'h31, 1,3'd5, 0,1, 8'hA0,0));
        vecs.push_back(mk(1,3'd7,8'h77, 1,3'd5,8'h32, 1,3'd5, 0,1, 8'hA0,0));
        vecs.push_back(mk(1,3'd7,8'h77, 1,3'd5,8'h33, 1,3'd5, 1,0, 8'hA0,0));
        vecs.push_back(mk(0,3'd0,8'h00, 1,3'd5,8'h33, 1,3'd5, 0,1, 8'h20,0));
        vecs.push_back(mk(0,3'd0,8'h00, 1,3'd5,8'h34, 1,3'd5, 0,1, 8'h20,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,0, 8'h00,0));
        // same-index set and clear: set wins
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd4, 0,0, 8'h10,0));
        vecs.push_back(mk(1,3'd4,8'h44, 0,3'd0,8'h00, 0,3'd0, 1,0, 8'h10,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd4, 0,0, 8'h10,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,0, 8'h10,0));
        // r0 handling (depends on build option)
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd0, 0,0, BusyR0,0));
        vecs.push_back(mk(1,3'd0,8'hFF, 0,3'd0,8'h00, 0,3'd0, 1,0, BusyR0,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,0, 8'h10,0));
        // write to a non-busy register raises sticky wb_err
        vecs.push_back(mk(1,3'd6,8'h66, 0,3'd0,8'h00, 0,3'd0, 1,0, 8'h10,0));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,0, 8'h10,1));
        vecs.push_back(mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,0, 8'h10,1));

        // reset for two cycles, then idle
        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset alu_ready", 32'(alu_ready), 32'd0);
        chk("reset mem_ready", 32'(mem_ready), 32'd0);
        chk("reset RegWrite", 32'(RegWrite), 32'd0);
        chk("reset WriteReg", 32'(WriteReg), 32'd0);
        chk("reset WriteData", 32'(WriteData), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset wb_err", 32'(wb_err), 32'd0);

        foreach (vecs[i]) begin
            commit_t c;
            @(negedge clk);
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
            issue_valid = vecs[i].iv; issue_reg = vecs[i].ir;
            #1;
            chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].expA));
            chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].expM));
            if (vecs[i].expA && !(R0Z && vecs[i].ar == 3'd0)) begin
                c.r = vecs[i].ar; c.d = vecs[i].ad; sb.push_back(c);
            end
            if (vecs[i].expM && !(R0Z && vecs[i].mr == 3'd0)) begin
                c.r = vecs[i].mr; c.d = vecs[i].md; sb.push_back(c);
            end
            @(posedge clk);
            #1;
            checkCommit(i);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
            chk($sformatf("v%0d wb_err", i), 32'(wb_err), 32'(vecs[i].expErr));
        end

        // reset mid-operation discards an accepted write and clears state
        @(negedge clk);
        alu_valid = 1'b1; alu_reg = 3'd2; alu_data = 8'h12;
        issue_valid = 1'b1; issue_reg = 3'd3;
        rst = 1'b1;
        #1;
        chk("midrst alu_ready", 32'(alu_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("midrst RegWrite", 32'(RegWrite), 32'd0);
        chk("midrst WriteReg", 32'(WriteReg), 32'd0);
        chk("midrst WriteData", 32'(WriteData), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst wb_err", 32'(wb_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        @(posedge clk);
        #1;
        chk("post-rst RegWrite", 32'(RegWrite), 32'd0);
        chk("post-rst busy", 32'(busy), 32'd0);
        chk("post-rst wb_err", 32'(wb_err), 32'd0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
